// File: rtl/msb_pkg.sv
// Shared sizing for the word assembler, the receiver and their bench.
package msb_pkg;

  localparam int DW_IN_DEF   = 512;
  localparam int DW_BEAT_DEF = 32;

  // Number of beats packed into one output word.
  function automatic int calc_beats(input int dw_in, input int dw_beat);
    return dw_in / dw_beat;
  endfunction

  // Width needed to hold a beat count from 0 up to and including BEATS.
  function automatic int calc_lw(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs DW_BEAT-wide input beats into one DW_IN-wide word (first beat in the
// LSBs) and presents it on a registered valid/ready output. An assembly
// register and an output register form a double buffer, so a new word can
// be collected while the previous one waits for the consumer.
// DW_IN must be an integer multiple of DW_BEAT.
module word_assembler
  import msb_pkg::*;
#(
  parameter  int DW_IN   = DW_IN_DEF,
  parameter  int DW_BEAT = DW_BEAT_DEF,
  localparam int BEATS   = calc_beats(DW_IN, DW_BEAT),
  localparam int LW      = calc_lw(BEATS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW_BEAT-1:0] s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [DW_IN-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [LW-1:0]      m_len
);

  // Assembly side: partial or parked word, next free slot, parked-word flag.
  logic [DW_IN-1:0] asm_q;
  logic [LW-1:0]    cnt_q;
  logic             asm_full_q;
  logic [LW-1:0]    pend_len_q;

  // Output side.
  logic [DW_IN-1:0] m_data_q;
  logic             m_valid_q;
  logic [LW-1:0]    m_len_q;

  logic             accept;
  logic             complete;
  logic             slot_free;
  logic             load_pend;
  logic [LW-1:0]    len_cur;
  logic [DW_IN-1:0] asm_d;

  // Handshake decode and the assembly word with the current beat merged in.
  always_comb begin
    s_ready   = !asm_full_q;
    accept    = s_valid && !asm_full_q;
    complete  = accept && ((cnt_q == LW'(BEATS - 1)) || s_last);
    slot_free = !m_valid_q || m_ready;
    // A parked word only exists while input is blocked, so it never
    // competes with an accepted beat for the output slot.
    load_pend = asm_full_q && slot_free;
    len_cur   = cnt_q + LW'(1);
    asm_d     = asm_q;
    if (accept) asm_d[int'(cnt_q) * DW_BEAT +: DW_BEAT] = s_data;
  end

  // Assembly register, beat counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      asm_full_q <= 1'b0;
      pend_len_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_len_q    <= '0;
    end else begin
      // Consumer took the word; cleared here, re-set below if a new one loads.
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;

      if (load_pend) begin
        m_data_q   <= asm_q;
        m_len_q    <= pend_len_q;
        m_valid_q  <= 1'b1;
        asm_q      <= '0;
        cnt_q      <= '0;
        asm_full_q <= 1'b0;
      end else if (complete) begin
        if (slot_free) begin
          // Straight through: one cycle from last beat to m_valid.
          m_data_q  <= asm_d;
          m_len_q   <= len_cur;
          m_valid_q <= 1'b1;
          asm_q     <= '0;
          cnt_q     <= '0;
        end else begin
          // Output busy: park the finished word and block the input.
          asm_q      <= asm_d;
          pend_len_q <= len_cur;
          asm_full_q <= 1'b1;
        end
      end else if (accept) begin
        asm_q <= asm_d;
        cnt_q <= len_cur;
      end
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_len   = m_len_q;

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler: stimulus pushes expected words into a
// scoreboard queue, a negedge monitor pops and compares on every output
// handshake.
module tb_word_assembler;
  import msb_pkg::*;

  localparam int DW_IN   = 512;
  localparam int DW_BEAT = 32;
  localparam int BEATS   = calc_beats(DW_IN, DW_BEAT);
  localparam int LW      = calc_lw(BEATS);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DW_BEAT-1:0] s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [DW_IN-1:0]   m_data;
  logic               m_valid;
  logic               m_ready;
  logic [LW-1:0]      m_len;

  word_assembler #(.DW_IN(DW_IN), .DW_BEAT(DW_BEAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_len(m_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW_IN-1:0] data;
    logic [LW-1:0]    len;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW_IN-1:0] got,
                     input logic [DW_IN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [DW_IN-1:0] d, input int len);
    exp_t e;
    e.data = d;
    e.len  = LW'(len);
    sb.push_back(e);
  endtask

  // Drive one beat; returns 1 time unit after the edge that accepted it.
  task automatic send_beat(input logic [DW_BEAT-1:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 200) begin
      total++; bad++;
      $display("FAIL send_timeout got=s_ready_low exp=s_ready_high");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", DW_IN'(sb.size()), '0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word got=%0h exp=none", m_data);
      end else begin
        e = sb.pop_front();
        chk("word_data", m_data, e.data);
        chk("word_len", DW_IN'(m_len), DW_IN'(e.len));
      end
    end
  end

  logic [DW_IN-1:0] wa, wb;
  int c0;

  initial begin
    rst_n = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;

    // 1. Asynchronous reset mid-cycle: outputs clear immediately.
    #12 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", DW_IN'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_len", DW_IN'(m_len), '0);
    chk("rst_s_ready", DW_IN'(s_ready), DW_IN'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;

    // 2. Two full words back to back, slot i holds i.
    wa = '0;
    for (int i = 0; i < 16; i++) wa[32*i +: 32] = 32'(i);
    push(wa, 16);
    for (int i = 0; i < 16; i++) send_beat(32'(i), 1'b0);
    @(negedge clk);
    chk("lat1_m_valid", DW_IN'(m_valid), DW_IN'(1));
    c0 = cyc;
    push(wa, 16);
    for (int i = 0; i < 16; i++) send_beat(32'(i), 1'b0);
    chk("b2b_cycles", DW_IN'(cyc - c0), DW_IN'(16));
    @(negedge clk);
    chk("lat2_m_valid", DW_IN'(m_valid), DW_IN'(1));
    drain();

    // 3. Short word closed by s_last, then a one-beat word.
    wa = '0;
    wa[95:0] = {32'h789, 32'h456, 32'h123};
    push(wa, 3);
    send_beat(32'h123, 1'b0);
    send_beat(32'h456, 1'b0);
    send_beat(32'h789, 1'b1);
    wa = '0;
    wa[31:0] = 32'hBEEF;
    push(wa, 1);
    send_beat(32'hBEEF, 1'b1);
    drain();

    // 4. Backpressure: A waits on the output, B parks in the assembler.
    wa = '0; wb = '0;
    for (int i = 0; i < 16; i++) begin
      wa[32*i +: 32] = 32'h1000 + 32'(i);
      wb[32*i +: 32] = 32'h2000 + 32'(i);
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    push(wa, 16);
    push(wb, 16);
    for (int i = 0; i < 16; i++) send_beat(32'h1000 + 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) send_beat(32'h2000 + 32'(i), 1'b0);
    chk("bp_s_ready_low", DW_IN'(s_ready), '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", DW_IN'(m_valid), DW_IN'(1));
      chk("bp_hold_data", m_data, wa);
      chk("bp_hold_len", DW_IN'(m_len), DW_IN'(16));
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("bp_b_valid", DW_IN'(m_valid), DW_IN'(1));
    chk("bp_b_data", m_data, wb);
    chk("bp_s_ready_back", DW_IN'(s_ready), DW_IN'(1));
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain();

    // 5. Reset mid-word discards the partial word.
    for (int i = 0; i < 5; i++) send_beat(32'h5000 + 32'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_m_valid", DW_IN'(m_valid), '0);
    chk("rst2_s_ready", DW_IN'(s_ready), DW_IN'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    wa = {16{32'hA5A5A5A5}};
    push(wa, 16);
    for (int i = 0; i < 16; i++) send_beat(32'hA5A5A5A5, 1'b0);
    drain();

    // 6. Input stalls mid-word; the word must not appear during the gap.
    wa = '0;
    for (int i = 0; i < 16; i++) wa[32*i +: 32] = 32'h600 + 32'(i);
    push(wa, 16);
    for (int i = 0; i < 8; i++) send_beat(32'h600 + 32'(i), 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("gap_no_valid", DW_IN'(m_valid), '0);
    end
    @(posedge clk); #1;
    for (int i = 8; i < 16; i++) send_beat(32'h600 + 32'(i), 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_assembler.md
Name: word_assembler

Overview:
- Upstream stage of `receiver`.
- Collects narrow input beats over a valid/ready stream and packs them into one DW_IN-bit word, first beat in the LSBs.
- Presents each packed word on a registered valid/ready output that drives receiver's `data` input.
- Double-buffered (assembly register plus output register), so input keeps flowing while the output word waits.

Parameters:
- DW_IN, 512, output word width; must equal receiver's DW_IN.
- DW_BEAT, 32, input beat width; DW_IN must be an integer multiple of DW_BEAT.
- BEATS, DW_IN/DW_BEAT, beats per word; localparam, not overridable.
- LW, $clog2(BEATS+1), width of m_len; localparam.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_data  input  DW_BEAT  input beat.
- s_valid  input  1  beat valid.
- s_last  input  1  final beat of a short word; the word closes early.
- s_ready  output  1  block can accept a beat.
- m_data  output  DW_IN  packed word to receiver.
- m_valid  output  1  m_data holds a complete word.
- m_ready  input  1  downstream takes the word.
- m_len  output  LW  number of valid beats in m_data, 1..BEATS.

Behaviour:
- Reset (rst_n low, asynchronous):
  - m_valid=0, m_data=0, m_len=0.
  - Assembly register, beat counter cnt and asm_full all cleared.
  - s_ready=1, since s_ready = !asm_full, a combinational function of the flag.
- Beat accept: s_valid && s_ready. The beat is written to slot cnt, bits [cnt*DW_BEAT +: DW_BEAT], then cnt increments.
- Word complete: an accepted beat with cnt==BEATS-1, or with s_last=1.
  - Slots above the last beat are zero.
  - len = cnt+1.
  - s_last on slot BEATS-1 is the same as a full word.
- Output slot free: !m_valid || m_ready, evaluated in the same cycle.
- Completion with the slot free:
  - Next edge: m_data gets the assembled word including the current beat, m_len=len, m_valid=1.
  - cnt=0 and the assembly register is cleared.
  - Latency is 1 cycle from the last accepted beat to m_valid.
- Completion with the slot busy:
  - The word stays in the assembly register, asm_full=1, so s_ready=0.
  - In the first cycle the slot becomes free, the word transfers on the next edge, asm_full=0 and cnt=0.
  - s_ready returns to 1 in the cycle after the transfer edge.
- Output drain: m_valid && m_ready with no pending word clears m_valid on the next edge. m_data keeps its value; nothing requires it to be zeroed.
- Output stability: while m_valid && !m_ready, m_data and m_len hold stable.
- Throughput: with m_ready=1 held, one word every BEATS cycles with no bubble between words.
- s_valid=0 mid-word: cnt and partial data are held indefinitely.
- s_last with cnt==0: a one-beat word, m_len=1.
- Protocol rule: s_data is ignored when !s_ready, and the upstream must hold it stable.
- Reset mid-operation: a partial word and any pending or output words are discarded. The first beat after reset lands in slot 0.
- BEATS==1: every accepted beat is a complete word; the same rules apply.

Decomposition:
- Shared package msb_pkg holds:
  - constants DW_IN_DEF=512 and DW_BEAT_DEF=32;
  - a function computing BEATS and LW, shared with receiver and the bench.
- No sub-module. Implement the assembly register, counter and output register flat in one always_ff, with a small combinational block for s_ready and transfer enables.

Test Plan (DW_IN=512, DW_BEAT=32, BEATS=16):
1. Reset:
   - Stimulus: rst_n=0 asserted asynchronously mid-cycle.
   - Response: m_valid=0, m_data=0, m_len=0, s_ready=1 immediately.
2. Full word, back to back:
   - Stimulus: 16 beats with s_data=i for i=0..15 on consecutive cycles, m_ready=1, then a second word on the following cycles.
   - Response: 1 cycle after beat 15, m_valid=1, m_data[32*i+:32]==i, m_len=16. The second word is accepted with no idle cycle; its m_valid follows 16 cycles later.
3. Short word:
   - Stimulus: beats 'h123, 'h456, 'h789, with s_last on 'h789.
   - Response: m_data[95:0]=={32'h789,32'h456,32'h123}, m_data[511:96]=0, m_len=3.
4. Backpressure:
   - Stimulus: m_ready=0 while 32 beats are sent.
   - Response:
     - Word A is presented and held stable.
     - Word B is assembled, asm_full=1 and s_ready=0 after beat 32.
     - When m_ready=1 for one cycle, A is consumed; on the next edge m_data==B and m_valid stays 1.
     - s_ready=1 in the cycle after that edge.
5. Reset mid-word:
   - Stimulus: 5 beats accepted, rst_n pulsed low, then 16 beats of 'hA5A5A5A5.
   - Response: the word contains only 'hA5A5A5A5 in all 16 slots, m_len=16.
6. Stalled input:
   - Stimulus: 8 beats, s_valid=0 for 10 cycles, then 8 more beats.
   - Response: exactly one word with all 16 beats in order; m_valid never asserts during the gap.
